// File: rtl/control_pipe.sv
// RV32I(+M) registered decode/control stage with a 1-entry valid/ready hold register.
// Optional RV32M_EN: decodes M-extension ops and holds them back for the MUL/DIV latency.
module control_pipe #(
  parameter int ALU_CTL_W  = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 reg_write_enable,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 dmem_write_enable,
  output logic                 dmem_read_enable,
  output logic                 branch,
  output logic                 branch_inv,
  output logic                 jump,
  output logic                 jump_reg,
  output logic                 pc_to_rf,
  output logic                 mdu_op,
  output logic                 mdu_busy,
  output logic                 illegal
);

  // state   | meaning
  // ST_RUN  | accepting instructions, held controls flow to execute
  // ST_WAIT | M-extension op held, counting down until the MDU result is due

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  typedef struct packed {
    logic [ALU_CTL_W-1:0] alu;
    logic rwe, src, m2r, dwe, dre, br, br_inv, jmp, jr, pc2rf, mdu, ill;
  } ctl_t;

  localparam logic [ALU_CTL_W-1:0] A_AND = ALU_CTL_W'(0),  A_OR    = ALU_CTL_W'(1);
  localparam logic [ALU_CTL_W-1:0] A_ADD = ALU_CTL_W'(2),  A_SUB   = ALU_CTL_W'(3);
  localparam logic [ALU_CTL_W-1:0] A_SLTU = ALU_CTL_W'(4), A_XOR   = ALU_CTL_W'(5);
  localparam logic [ALU_CTL_W-1:0] A_SLL = ALU_CTL_W'(6),  A_SRL   = ALU_CTL_W'(7);
  localparam logic [ALU_CTL_W-1:0] A_SRA = ALU_CTL_W'(8),  A_LUI   = ALU_CTL_W'(9);
  localparam logic [ALU_CTL_W-1:0] A_SLT = ALU_CTL_W'(10), A_BGEU  = ALU_CTL_W'(19);
  localparam logic [ALU_CTL_W-1:0] A_BGE = ALU_CTL_W'(20);
`ifdef RV32M_EN
  localparam logic [ALU_CTL_W-1:0] A_DIVU = ALU_CTL_W'(11), A_DIV    = ALU_CTL_W'(12);
  localparam logic [ALU_CTL_W-1:0] A_REMU = ALU_CTL_W'(13), A_REM    = ALU_CTL_W'(14);
  localparam logic [ALU_CTL_W-1:0] A_MUL  = ALU_CTL_W'(15), A_MULHU  = ALU_CTL_W'(16);
  localparam logic [ALU_CTL_W-1:0] A_MULHSU = ALU_CTL_W'(17), A_MULH = ALU_CTL_W'(18);
  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N) + 1;
`else
  localparam int unused_cycles = MUL_CYCLES + DIV_CYCLES;
`endif

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_bits;
  ctl_t       dec, held, held_n;
  state_t     state, state_n;
  logic       out_valid_n, accept;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '0;
    case (opcode)
      7'b0110011: begin
        dec.rwe = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu = A_ADD;
            3'b001:  dec.alu = A_SLL;
            3'b010:  dec.alu = A_SLT;
            3'b011:  dec.alu = A_SLTU;
            3'b100:  dec.alu = A_XOR;
            3'b101:  dec.alu = A_SRL;
            3'b110:  dec.alu = A_OR;
            default: dec.alu = A_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu = A_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu = A_SRA;
`ifdef RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          dec.mdu = 1'b1;
          case (funct3)
            3'b000:  dec.alu = A_MUL;
            3'b001:  dec.alu = A_MULH;
            3'b010:  dec.alu = A_MULHSU;
            3'b011:  dec.alu = A_MULHU;
            3'b100:  dec.alu = A_DIV;
            3'b101:  dec.alu = A_DIVU;
            3'b110:  dec.alu = A_REM;
            default: dec.alu = A_REMU;
          endcase
`endif
        end else begin
          dec.ill = 1'b1;
        end
      end
      7'b0010011: begin
        dec.rwe = 1'b1;
        dec.src = 1'b1;
        case (funct3)
          3'b000:  dec.alu = A_ADD;
          3'b001:  dec.alu = A_SLL;
          3'b010:  dec.alu = A_SLT;
          3'b011:  dec.alu = A_SLTU;
          3'b100:  dec.alu = A_XOR;
          3'b101:  dec.alu = funct7[5] ? A_SRA : A_SRL;
          3'b110:  dec.alu = A_OR;
          default: dec.alu = A_AND;
        endcase
      end
      7'b0000011: begin
        dec.alu = A_ADD; dec.src = 1'b1; dec.rwe = 1'b1;
        dec.m2r = 1'b1;  dec.dre = 1'b1;
      end
      7'b0100011: begin
        dec.alu = A_ADD; dec.src = 1'b1; dec.dwe = 1'b1;
      end
      7'b1100011: begin
        dec.br     = 1'b1;
        dec.br_inv = (funct3 != 3'b000);
        case (funct3)
          3'b000, 3'b001: dec.alu = A_SUB;
          3'b100:         dec.alu = A_SLT;
          3'b101:         dec.alu = A_BGE;
          3'b110:         dec.alu = A_SLTU;
          3'b111:         dec.alu = A_BGEU;
          default:        dec.ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec.alu = A_LUI; dec.src = 1'b1; dec.rwe = 1'b1;
      end
      7'b0010111: begin
        dec.alu = A_ADD; dec.src = 1'b1; dec.rwe = 1'b1; dec.pc2rf = 1'b1;
      end
      7'b1101111: begin
        dec.alu = A_ADD; dec.rwe = 1'b1; dec.jmp = 1'b1;
      end
      7'b1100111: begin
        dec.alu = A_ADD; dec.src = 1'b1; dec.rwe = 1'b1; dec.jr = 1'b1;
      end
      7'b0001111, 7'b1110011: dec = '0;
      default: dec.ill = 1'b1;
    endcase
    // An undecodable instruction still flows, but must not enable anything downstream.
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign in_ready = ~rst & (state == ST_RUN) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

`ifdef RV32M_EN
  logic [CNT_W-1:0] count, count_n, mdu_n;
  assign mdu_n = instr[14] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
`endif

  always_comb begin
    state_n     = state;
    out_valid_n = out_valid;
    held_n      = held;
`ifdef RV32M_EN
    count_n     = count;
`endif
    if (flush) begin
      out_valid_n = 1'b0;
      state_n     = ST_RUN;
`ifdef RV32M_EN
      count_n     = '0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (out_ready) out_valid_n = 1'b0;
          if (accept) begin
            held_n      = dec;
            out_valid_n = 1'b1;
`ifdef RV32M_EN
            if (dec.mdu && mdu_n != '0) begin
              out_valid_n = 1'b0;
              count_n     = mdu_n;
              state_n     = ST_WAIT;
            end
`endif
          end
        end
        ST_WAIT: begin
`ifdef RV32M_EN
          // Result is due in the cycle the count reaches zero.
          if (count <= CNT_W'(1)) begin
            count_n     = '0;
            out_valid_n = 1'b1;
            state_n     = ST_RUN;
          end else begin
            count_n = count - CNT_W'(1);
          end
`else
          state_n = ST_RUN;
`endif
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      out_valid <= 1'b0;
      held      <= '0;
`ifdef RV32M_EN
      count     <= '0;
`endif
    end else begin
      state     <= state_n;
      out_valid <= out_valid_n;
      held      <= held_n;
`ifdef RV32M_EN
      count     <= count_n;
`endif
    end
  end

  assign alu_ctl           = held.alu;
  assign reg_write_enable  = held.rwe;
  assign alu_src           = held.src;
  assign mem_to_reg        = held.m2r;
  assign dmem_write_enable = held.dwe;
  assign dmem_read_enable  = held.dre;
  assign branch            = held.br;
  assign branch_inv        = held.br_inv;
  assign jump              = held.jmp;
  assign jump_reg          = held.jr;
  assign pc_to_rf          = held.pc2rf;
  assign illegal           = held.ill;
`ifdef RV32M_EN
  assign mdu_op   = held.mdu;
  assign mdu_busy = (state == ST_WAIT);
`else
  assign mdu_op   = 1'b0;
  assign mdu_busy = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode table plus hold, flush, reset and MDU latency sequences.
module tb_control_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [4:0]  alu_ctl;
  logic        reg_write_enable, alu_src, mem_to_reg, dmem_write_enable, dmem_read_enable;
  logic        branch, branch_inv, jump, jump_reg, pc_to_rf, mdu_op, mdu_busy, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
    .reg_write_enable(reg_write_enable), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .dmem_write_enable(dmem_write_enable), .dmem_read_enable(dmem_read_enable),
    .branch(branch), .branch_inv(branch_inv), .jump(jump), .jump_reg(jump_reg),
    .pc_to_rf(pc_to_rf), .mdu_op(mdu_op), .mdu_busy(mdu_busy), .illegal(illegal)
  );

  // flag order: rwe src m2r dwe dre br br_inv jmp jr pc2rf
  typedef struct {
    logic [31:0] instr;
    logic        chk_alu;
    logic [4:0]  alu;
    logic [9:0]  flags;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SLTI = 32'h00502093;
  localparam logic [9:0]  F_LW   = 10'b1110100000;

  function automatic logic [9:0] flags_now();
    return {reg_write_enable, alu_src, mem_to_reg, dmem_write_enable, dmem_read_enable,
            branch, branch_inv, jump, jump_reg, pc_to_rf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{32'h002081B3, 1'b1, 5'd2,  10'b1000000000, 1'b0}); // add
    vecs.push_back('{32'h00209063, 1'b1, 5'd3,  10'b0000011000, 1'b0}); // bne
    vecs.push_back('{32'h402081B3, 1'b1, 5'd3,  10'b1000000000, 1'b0}); // sub
    vecs.push_back('{32'h0080A283, 1'b1, 5'd2,  10'b1110100000, 1'b0}); // lw
    vecs.push_back('{32'h0020A223, 1'b1, 5'd2,  10'b0101000000, 1'b0}); // sw
    vecs.push_back('{32'h00500093, 1'b1, 5'd2,  10'b1100000000, 1'b0}); // addi
    vecs.push_back('{32'h00502093, 1'b1, 5'd10, 10'b1100000000, 1'b0}); // slti
    vecs.push_back('{32'h00503093, 1'b1, 5'd4,  10'b1100000000, 1'b0}); // sltiu
    vecs.push_back('{32'h4030D093, 1'b1, 5'd8,  10'b1100000000, 1'b0}); // srai
    vecs.push_back('{32'h0030D093, 1'b1, 5'd7,  10'b1100000000, 1'b0}); // srli
    vecs.push_back('{32'h123450B7, 1'b1, 5'd9,  10'b1100000000, 1'b0}); // lui
    vecs.push_back('{32'h00001097, 1'b1, 5'd2,  10'b1100000001, 1'b0}); // auipc
    vecs.push_back('{32'h000000EF, 1'b1, 5'd2,  10'b1000000100, 1'b0}); // jal
    vecs.push_back('{32'h000100E7, 1'b1, 5'd2,  10'b1100000010, 1'b0}); // jalr
    vecs.push_back('{32'h00208063, 1'b1, 5'd3,  10'b0000010000, 1'b0}); // beq
    vecs.push_back('{32'h0020C063, 1'b1, 5'd10, 10'b0000011000, 1'b0}); // blt
    vecs.push_back('{32'h0020D063, 1'b1, 5'd20, 10'b0000011000, 1'b0}); // bge
    vecs.push_back('{32'h0020E063, 1'b1, 5'd4,  10'b0000011000, 1'b0}); // bltu
    vecs.push_back('{32'h0020F063, 1'b1, 5'd19, 10'b0000011000, 1'b0}); // bgeu
    vecs.push_back('{32'h0020F1B3, 1'b1, 5'd0,  10'b1000000000, 1'b0}); // and
    vecs.push_back('{32'h0020E1B3, 1'b1, 5'd1,  10'b1000000000, 1'b0}); // or
    vecs.push_back('{32'h0020C1B3, 1'b1, 5'd5,  10'b1000000000, 1'b0}); // xor
    vecs.push_back('{32'h002091B3, 1'b1, 5'd6,  10'b1000000000, 1'b0}); // sll
    vecs.push_back('{32'h0020A1B3, 1'b1, 5'd10, 10'b1000000000, 1'b0}); // slt
    vecs.push_back('{32'h0020B1B3, 1'b1, 5'd4,  10'b1000000000, 1'b0}); // sltu
    vecs.push_back('{32'h0020D1B3, 1'b1, 5'd7,  10'b1000000000, 1'b0}); // srl
    vecs.push_back('{32'h4020D1B3, 1'b1, 5'd8,  10'b1000000000, 1'b0}); // sra
    vecs.push_back('{32'h0000000F, 1'b0, 5'd0,  10'b0000000000, 1'b0}); // fence
    vecs.push_back('{32'h00000073, 1'b0, 5'd0,  10'b0000000000, 1'b0}); // ecall
    vecs.push_back('{32'h0020A063, 1'b0, 5'd0,  10'b0000000000, 1'b1}); // branch f3=010
    vecs.push_back('{32'h0000007F, 1'b0, 5'd0,  10'b0000000000, 1'b1}); // opcode 0x7F
    vecs.push_back('{32'h042081B3, 1'b0, 5'd0,  10'b0000000000, 1'b1}); // bad funct7
`ifndef RV32M_EN
    vecs.push_back('{32'h022081B3, 1'b0, 5'd0,  10'b0000000000, 1'b1}); // mul w/o M
`endif

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; instr = I_ADD; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ctl", {alu_ctl, flags_now(), mdu_op, mdu_busy, illegal}, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Back-to-back through the decode table: each cycle consumes and accepts.
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_flags", i), flags_now(), vecs[i].flags);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      chk($sformatf("vec%0d_mdu_op", i), mdu_op, 1'b0);
      if (vecs[i].chk_alu) chk($sformatf("vec%0d_alu", i), alu_ctl, vecs[i].alu);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", out_valid, 1'b0);

    // Execute stalls with lw held; a pending slti must wait.
    begin
      int bad = 0;
      in_valid = 1'b1; instr = I_LW; out_ready = 1'b0;
      tick();
      instr = I_SLTI;
      for (int k = 0; k < 5; k++) begin
        if (!(out_valid && !in_ready && alu_ctl == 5'd2 && flags_now() == F_LW)) bad++;
        tick();
      end
      chk("stall_hold_bad_cycles", bad, 0);
      out_ready = 1'b1;
      #1;
      chk("stall_release_in_ready", in_ready, 1'b1);
      tick();
      chk("stall_next_valid", out_valid, 1'b1);
      chk("stall_next_alu", alu_ctl, 5'd10);
      in_valid = 1'b0;
      tick();
      chk("stall_drain", out_valid, 1'b0);
    end

    // Flush drops the held lw and ignores the instruction presented with it.
    in_valid = 1'b1; instr = I_LW; out_ready = 1'b0;
    tick();
    chk("flush_pre_valid", out_valid, 1'b1);
    flush = 1'b1; instr = I_ADD; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    tick();
    chk("flush_no_accept", out_valid, 1'b0);

`ifdef RV32M_EN
    begin
      int bad = 0;
      in_valid = 1'b1; instr = 32'h0220C1B3; out_ready = 1'b1; // div
      tick();
      instr = I_ADD;
      for (int k = 1; k <= 32; k++) begin
        if (!(mdu_busy && !out_valid && !in_ready && mdu_op)) bad++;
        if (k < 32) tick();
      end
      chk("div_wait_bad_cycles", bad, 0);
      tick();
      chk("div_out_valid", out_valid, 1'b1);
      chk("div_busy_done", mdu_busy, 1'b0);
      chk("div_alu", alu_ctl, 5'd12);
      chk("div_in_ready", in_ready, 1'b1);
      tick();
      chk("div_next_add", {out_valid, alu_ctl, mdu_op}, {1'b1, 5'd2, 1'b0});
      in_valid = 1'b0;
      tick();

      in_valid = 1'b1; instr = 32'h022081B3; // mul, 2 cycles
      tick();
      in_valid = 1'b0;
      chk("mul_t1", {out_valid, mdu_busy}, 2'b01);
      tick();
      chk("mul_t2", {out_valid, mdu_busy, alu_ctl}, {1'b1, 1'b0, 5'd15});
      tick();

      bad = 0;
      in_valid = 1'b1; instr = 32'h0220C1B3;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("divflush_busy", mdu_busy, 1'b0);
      chk("divflush_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 40; k++) begin
        if (out_valid) bad++;
        tick();
      end
      chk("divflush_never_valid", bad, 0);

      bad = 0;
      in_valid = 1'b1; instr = 32'h0220C1B3;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("divrst_busy", {mdu_busy, mdu_op}, 2'b00);
      for (int k = 0; k < 40; k++) begin
        if (out_valid) bad++;
        tick();
      end
      chk("divrst_never_valid", bad, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
